// File: rtl/mux_key_reg.sv
// Keyed-selection register: a packed lookup table picks a data word by key, and
// a resettable, write-enabled register captures it. Optional MUX_KEY_REG_DEFAULT_EN
// drives default_out on a key miss (otherwise a miss selects all zeros).
module mux_key_reg #(
  parameter int unsigned                NR_KEY    = 2,
  parameter int unsigned                KEY_LEN   = 1,
  parameter int unsigned                DATA_LEN  = 32,
  parameter logic [DATA_LEN-1:0]        RESET_VAL = 32'h8000_0000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [KEY_LEN-1:0]            key,
  input  logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0] lut,
  input  logic [DATA_LEN-1:0]           default_out,
  input  logic                          wen,
  output logic [DATA_LEN-1:0]           mux_out,
  output logic [DATA_LEN-1:0]           dout
);

  localparam int unsigned ENTRY_LEN = KEY_LEN + DATA_LEN;

  logic [KEY_LEN-1:0]  entry_key  [NR_KEY];
  logic [DATA_LEN-1:0] entry_data [NR_KEY];
  logic [NR_KEY-1:0]   hit;
  logic [DATA_LEN-1:0] miss_val;
  logic [DATA_LEN-1:0] sel_data;
  logic [DATA_LEN-1:0] dout_d;
  // Simulation starts from the reset value; silicon is undefined until the first reset edge.
  logic [DATA_LEN-1:0] dout_q = RESET_VAL;

  generate
    for (genvar gi = 0; gi < NR_KEY; gi++) begin : g_entry
      assign entry_key[gi]  = lut[gi*ENTRY_LEN + DATA_LEN +: KEY_LEN];
      assign entry_data[gi] = lut[gi*ENTRY_LEN +: DATA_LEN];
      assign hit[gi]        = (entry_key[gi] == key);
    end
  endgenerate

`ifdef MUX_KEY_REG_DEFAULT_EN
  assign miss_val = default_out;
`else
  logic unused_default;
  assign unused_default = ^default_out;
  assign miss_val       = '0;
`endif

  // Walk from the top index down so the lowest matching index is the last to assign.
  always_comb begin
    sel_data = miss_val;
    for (int i = NR_KEY - 1; i >= 0; i--) begin
      if (hit[i]) begin
        sel_data = entry_data[i];
      end
    end
  end

  assign mux_out = sel_data;

  always_comb begin
    dout_d = dout_q;
    if (wen) begin
      dout_d = sel_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= RESET_VAL;
    end else begin
      dout_q <= dout_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: tb/tb_mux_key_reg.sv
// Directed self-checking bench for mux_key_reg: PC-style instance (KEY_LEN=1)
// plus a KEY_LEN=2 instance for key-miss and duplicate-key selection.
module tb_mux_key_reg;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // PC-style instance
  logic        rst, wen, key;
  logic [31:0] snpc, dnpc, default_out, mux_out, dout;
  logic [65:0] lut;
  assign lut = {1'b0, snpc, 1'b1, dnpc};

  mux_key_reg #(.NR_KEY(2), .KEY_LEN(1), .DATA_LEN(32), .RESET_VAL(32'h8000_0000)) dut (
    .clk(clk), .rst(rst), .key(key), .lut(lut), .default_out(default_out),
    .wen(wen), .mux_out(mux_out), .dout(dout)
  );

  // Two-bit-key instance
  logic        rst_b, wen_b;
  logic [1:0]  key_b, k0_b, k1_b;
  logic [31:0] d0_b, d1_b, default_b, mux_out_b, dout_b;
  logic [67:0] lut_b;
  assign lut_b = {k1_b, d1_b, k0_b, d0_b};

  mux_key_reg #(.NR_KEY(2), .KEY_LEN(2), .DATA_LEN(32), .RESET_VAL(32'h8000_0000)) dut_b (
    .clk(clk), .rst(rst_b), .key(key_b), .lut(lut_b), .default_out(default_b),
    .wen(wen_b), .mux_out(mux_out_b), .dout(dout_b)
  );

  int n_pass  = 0;
  int n_total = 0;
  logic [31:0] exp_pc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    n_total++;
    if (dout !== 32'h8000_0000) $display("FAIL sim_init: dout=%h expected %h", dout, 32'h8000_0000);
    else begin n_pass++; $display("sim_init dout=%h", dout); end
    rst = 1'b1; wen = 1'b1; key = 1'b0; snpc = 32'h0000_1234; dnpc = 32'h0000_5678;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_total++;
      if (dout !== 32'h8000_0000) $display("FAIL reset_edge%0d: dout=%h expected %h", i, dout, 32'h8000_0000);
      else begin n_pass++; $display("reset_edge%0d dout=%h", i, dout); end
    end
    rst = 1'b0;
    exp_pc = 32'h8000_0000;
  endtask

  task automatic test_sequential();
    key = 1'b0; wen = 1'b1;
    for (int i = 0; i < 3; i++) begin
      snpc = exp_pc + 32'd4;
      #1;
      n_total++;
      if (mux_out !== exp_pc + 32'd4) $display("FAIL seq_mux%0d: mux_out=%h expected %h", i, mux_out, exp_pc + 32'd4);
      else n_pass++;
      tick();
      exp_pc = exp_pc + 32'd4;
      n_total++;
      if (dout !== exp_pc) $display("FAIL seq_dout%0d: dout=%h expected %h", i, dout, exp_pc);
      else begin n_pass++; $display("seq%0d dout=%h", i, dout); end
    end
  endtask

  task automatic test_jump();
    key = 1'b1; dnpc = 32'h8000_0100; snpc = exp_pc + 32'd4; wen = 1'b1;
    #1;
    n_total++;
    if (mux_out !== 32'h8000_0100) $display("FAIL jump_mux: mux_out=%h expected %h", mux_out, 32'h8000_0100);
    else n_pass++;
    tick();
    n_total++;
    if (dout !== 32'h8000_0100) $display("FAIL jump_dout: dout=%h expected %h", dout, 32'h8000_0100);
    else begin n_pass++; $display("jump dout=%h", dout); end
    exp_pc = 32'h8000_0100;
  endtask

  task automatic test_hold();
    wen = 1'b0; snpc = 32'h8000_0104; dnpc = 32'h8000_0200;
    for (int i = 0; i < 2; i++) begin
      key = i[0] ? 1'b1 : 1'b0;
      #1;
      n_total++;
      if (mux_out !== (i[0] ? 32'h8000_0200 : 32'h8000_0104))
        $display("FAIL hold_mux%0d: mux_out=%h expected %h", i, mux_out, i[0] ? 32'h8000_0200 : 32'h8000_0104);
      else n_pass++;
      tick();
      n_total++;
      if (dout !== 32'h8000_0100) $display("FAIL hold_dout%0d: dout=%h expected %h", i, dout, 32'h8000_0100);
      else begin n_pass++; $display("hold%0d dout=%h", i, dout); end
    end
  endtask

  task automatic test_reset_mid();
    rst = 1'b1; wen = 1'b1; key = 1'b1; dnpc = 32'h8000_0300;
    tick();
    n_total++;
    if (dout !== 32'h8000_0000) $display("FAIL reset_mid: dout=%h expected %h", dout, 32'h8000_0000);
    else begin n_pass++; $display("reset_mid dout=%h", dout); end
    rst = 1'b0;
    tick();
    n_total++;
    if (dout !== 32'h8000_0300) $display("FAIL reset_release: dout=%h expected %h", dout, 32'h8000_0300);
    else begin n_pass++; $display("reset_release dout=%h", dout); end
  endtask

  task automatic test_nomatch_dup();
    logic [31:0] exp_miss;
`ifdef MUX_KEY_REG_DEFAULT_EN
    exp_miss = 32'hDEAD_BEEF;
`else
    exp_miss = 32'h0000_0000;
`endif
    rst_b = 1'b0; wen_b = 1'b0;
    k0_b = 2'd0; d0_b = 32'h0000_AAAA; k1_b = 2'd1; d1_b = 32'h0000_BBBB;
    default_b = 32'hDEAD_BEEF; key_b = 2'd3;
    #1;
    n_total++;
    if (mux_out_b !== exp_miss) $display("FAIL nomatch: mux_out=%h expected %h", mux_out_b, exp_miss);
    else begin n_pass++; $display("nomatch mux_out=%h", mux_out_b); end
    key_b = 2'd1;
    #1;
    n_total++;
    if (mux_out_b !== 32'h0000_BBBB) $display("FAIL key1_b: mux_out=%h expected %h", mux_out_b, 32'h0000_BBBB);
    else n_pass++;
    k0_b = 2'd2; d0_b = 32'h0000_0011; k1_b = 2'd2; d1_b = 32'h0000_0022; key_b = 2'd2;
    #1;
    n_total++;
    if (mux_out_b !== 32'h0000_0011) $display("FAIL dup_mux: mux_out=%h expected %h", mux_out_b, 32'h0000_0011);
    else begin n_pass++; $display("dup mux_out=%h", mux_out_b); end
    wen_b = 1'b1;
    tick();
    n_total++;
    if (dout_b !== 32'h0000_0011) $display("FAIL dup_dout: dout=%h expected %h", dout_b, 32'h0000_0011);
    else begin n_pass++; $display("dup dout=%h", dout_b); end
    wen_b = 1'b0;
  endtask

  initial begin
    rst = 1'b0; wen = 1'b0; key = 1'b0; snpc = '0; dnpc = '0; default_out = 32'hDEAD_BEEF;
    rst_b = 1'b1; wen_b = 1'b0; key_b = '0; k0_b = '0; k1_b = '0; d0_b = '0; d1_b = '0; default_b = '0;
    #1;
    test_reset();
    test_sequential();
    test_jump();
    test_hold();
    test_reset_mid();
    test_nomatch_dup();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
